stage_sequencer: RTL

Multi-cycle control FSM that sequences the core's fetch, decode, execute, memory and writeback steps around the existing `execute` unit. It owns the architectural PC register and drives the per-step enable strobes. It also runs the instruction-memory and data-memory request/acknowledge handshakes. It sits between the fetch/decode logic, the `execute` datapath and the register file, and is the only block that advances the PC.

---
 rtl/stage_sequencer_if.sv | 29 ++
 rtl/stage_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/stage_sequencer_if.sv
// stage_sequencer_if: instruction- and data-memory request/acknowledge bundle
// between the stage sequencer (master) and the memory side (slave).
//
// Handshake: a request (imem_req / dmem_req) is held high until the matching
// acknowledge is seen high in the same cycle; that cycle completes the
// transfer. An acknowledge while the matching request is low means nothing.
interface stage_sequencer_if;
    logic imem_req;
    logic imem_ack;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ack;

    modport master (
        output imem_req,
        output dmem_req,
        output dmem_we,
        input  imem_ack,
        input  dmem_ack
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        input  dmem_we,
        output imem_ack,
        output dmem_ack
    );
endinterface

// File: rtl/stage_sequencer.sv
// stage_sequencer: multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK control
// FSM. Owns the architectural PC, drives the per-step strobes and runs the
// imem/dmem request/acknowledge handshakes through stage_sequencer_if.
//
// Optional feature: define SEQ_INSTRET_EN to add a 32-bit retired-instruction
// counter on output port `instret` (wraps to 0 after 32'hFFFF_FFFF).
module stage_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                is_load,
    input  logic                is_store,
    input  logic [31:0]         next_pc,
    stage_sequencer_if.master   mem_if,
    output logic [31:0]         pc,
    output logic                decode_en,
    output logic                exec_en,
    output logic                wb_en,
    output logic                retire,
    output logic                fault,
    output logic [2:0]          state
`ifdef SEQ_INSTRET_EN
    ,
    output logic [31:0]         instret
`endif
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] npc_q, npc_d;
    logic        req_pend_q, req_pend_d;
    logic        fault_q, fault_d;
    logic        mem_q, mem_d;
    logic        st_q, st_d;
    // High in the first cycle after EXECUTE, when next_pc is valid.
    logic        post_exec_q, post_exec_d;
    // High in the cycle right after reset; keeps requests low for that cycle.
    logic        boot_q, boot_d;

    logic        imem_req;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] npc_eff;

`ifdef SEQ_INSTRET_EN
    logic [31:0] instret_q, instret_d;
`endif

    // Next-state, strobe and handshake logic.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_pend_d  = req_pend_q;
        fault_d     = fault_q;
        mem_d       = mem_q;
        st_d        = st_q;
        post_exec_d = (state_q == S_EXECUTE);
        boot_d      = 1'b0;
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        decode_en   = 1'b0;
        exec_en     = 1'b0;
        wb_en       = 1'b0;
        retire      = 1'b0;

        // next_pc is only valid the cycle after EXECUTE; after that use the copy.
        npc_eff = post_exec_q ? next_pc : npc_q;
        npc_d   = npc_eff;

        case (state_q)
            S_FETCH: begin
                // A pending request ignores stall until acknowledged.
                imem_req = !boot_q && (req_pend_q || !stall);
                if (imem_req) begin
                    if (mem_if.imem_ack) begin
                        req_pend_d = 1'b0;
                        state_d    = S_DECODE;
                    end else begin
                        req_pend_d = 1'b1;
                    end
                end
            end
            S_DECODE: begin
                decode_en = 1'b1;
                state_d   = S_EXECUTE;
            end
            S_EXECUTE: begin
                exec_en = 1'b1;
                mem_d   = is_load || is_store;
                st_d    = is_store;
                state_d = (is_load || is_store) ? S_MEMORY : S_WRITEBACK;
            end
            S_MEMORY: begin
                dmem_req = 1'b1;
                dmem_we  = st_q;
                // mem_q is always set here; the guard only keeps a non-memory
                // instruction from ever waiting on dmem_ack.
                if (mem_if.dmem_ack || !mem_q) begin
                    state_d = S_WRITEBACK;
                end
            end
            S_WRITEBACK: begin
                wb_en  = !st_q;
                retire = 1'b1;
                if (npc_eff[1:0] != 2'b00) begin
                    fault_d = 1'b1;
                    state_d = S_HALT;
                end else begin
                    pc_d    = npc_eff;
                    state_d = S_FETCH;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            npc_q       <= RESET_PC;
            req_pend_q  <= 1'b0;
            fault_q     <= 1'b0;
            mem_q       <= 1'b0;
            st_q        <= 1'b0;
            post_exec_q <= 1'b0;
            boot_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            npc_q       <= npc_d;
            req_pend_q  <= req_pend_d;
            fault_q     <= fault_d;
            mem_q       <= mem_d;
            st_q        <= st_d;
            post_exec_q <= post_exec_d;
            boot_q      <= boot_d;
        end
    end

`ifdef SEQ_INSTRET_EN
    // Retired-instruction count, advanced by the retire pulse.
    always_comb begin
        instret_d = instret_q;
        if (retire) begin
            instret_d = instret_q + 32'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            instret_q <= 32'd0;
        end else begin
            instret_q <= instret_d;
        end
    end

    assign instret = instret_q;
`endif

    assign mem_if.imem_req = imem_req;
    assign mem_if.dmem_req = dmem_req;
    assign mem_if.dmem_we  = dmem_we;
    assign pc              = pc_q;
    assign fault           = fault_q;
    assign state           = state_q;

endmodule
